addsub_serial: RTL
==================

Name: addsub_serial

Overview:
- Parametrised multi-cycle adder/subtractor for the field-arithmetic datapath of the EdDSA core.
- Processes SIZE-bit operands one LIMB-bit limb per cycle, using a registered carry/borrow.
- Generalises the existing single-mode `add` unit: configurable limb width, runtime add/sub select, busy/done handshake, optional modular correction.
- Sits beside the multiplier/reducer in the point-arithmetic sequencer.

Parameters:
- SIZE, DATA_WIDTH (448), operand width in bits.
- LIMB, 64, limb width per cycle (1..SIZE); NUM_LIMBS = ceil(SIZE/LIMB) is a derived localparam.
- MODULUS, 2^448-2^224-1, field prime; used only when ADDSUB_MOD_EN is defined.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request; sampled on rising edge when busy=0.
- op  in  1  0 = a+b, 1 = a-b; latched with start.
- a  in  SIZE  operand A; latched with start.
- b  in  SIZE  operand B; latched with start.
- result  out  SIZE+1  sum/difference plus carry/borrow bit.
- done  out  1  one-cycle pulse when result is valid.
- busy  out  1  high while an operation is in progress.

Behaviour:
- Reset (rst=0, async): result=0, done=0, busy=0, state=IDLE, carry=0, limb index=0.
- States: IDLE -> RUN -> (CORR, macro only) -> DONE -> IDLE.
- IDLE: busy=0. When start=1 at an edge:
  - latch a, b, op;
  - zero-extend operands to NUM_LIMBS*LIMB bits;
  - set limb index to 0;
  - set carry = op (the +1 for two's-complement subtract);
  - go to RUN.
- RUN: busy=1. Each edge adds limb i of A to limb i of B' (B' = B for add, ~B masked to SIZE bits for sub), plus carry. The limb sum is stored and the new carry registered.
- RUN exit: after limb NUM_LIMBS-1, go to DONE (or CORR with the macro).
- Width rules:
  - add: result = {carry-out at bit SIZE, sum[SIZE-1:0]}.
  - sub: result[SIZE-1:0] = (a-b) mod 2^SIZE; result[SIZE] = borrow = NOT carry-out at bit SIZE, so it is 1 iff a<b.
  - When SIZE is not a multiple of LIMB, bits above SIZE in the top limb never reach result.
- DONE: done=1 for exactly one cycle, busy=0, result updated on entry to DONE. Next state is IDLE.
- Back-to-back: start=1 during the DONE cycle is accepted (busy=0), and the unit goes directly to RUN.
- Latency (no macro): done is high in the cycle after the NUM_LIMBS-th rising edge following the start-sampling edge. Defaults: 7 edges.
- Between operations: result holds its last value until the next DONE; it is not cleared at start.
- start while busy=1: ignored; latched operands are unaffected.
- Input changes on a/b/op after the start-sampling edge have no effect.
- Reset asserted mid-operation: immediate return to reset values, no done pulse. The first start after reset release begins a fresh operation.
- X on a/b/op when start=0: no effect.

Optional Feature:
- Macro: ADDSUB_MOD_EN.
- Defined: after RUN, enter CORR for NUM_LIMBS further cycles with a trial limb-serial pass on the stored value s:
  - add: t = s - MODULUS; result = (trial borrow) ? s : t.
  - sub: if the RUN borrow is set, t = s + MODULUS (mod 2^SIZE) and result = t; else result = s.
  - result[SIZE] = 0 always.
  - Inputs must be < MODULUS; behaviour otherwise is unspecified but must not hang.
  - Latency becomes 2*NUM_LIMBS edges (defaults: 14).
- Undefined: no CORR state, no MODULUS logic, plain integer behaviour as above.

Test Plan:
- Carry ripple across limbs: add, a=2^448-1, b=1 -> result=449'h1_0000...0 (bit 448 set), done exactly 7 edges after start, busy high for 7 cycles.
- Subtract with borrow: sub, a=0, b=1 -> result = {1'b1, 448 ones}. Sub, a=5, b=3 -> result=2, bit 448=0.
- Back-to-back and ignored start:
  - start again in the DONE cycle with a=b=2^447 -> result=449'h1_000...0;
  - an extra start pulse asserted mid-RUN produces no second done and no operand change.
- Reset mid-RUN: drop rst at limb 3 -> result=0, done/busy=0 immediately; a new add 3+4 after release -> result=7.
- Parameter sweep SIZE=100, LIMB=32 (4 limbs, partial top limb): a=2^100-1, b=2^100-1 add -> result=2^101-2; sub -> result=0, bit 100=0.
- ADDSUB_MOD_EN with the default MODULUS p:
  - add a=p-1, b=2 -> 1;
  - sub a=0, b=1 -> p-1;
  - add 3+4 -> 7;
  - done after 14 edges.

Source files
------------

// File: rtl/addsub_serial.sv
// Limb-serial SIZE-bit adder/subtractor with registered carry and busy/done handshake.
// Define ADDSUB_MOD_EN to add a second limb-serial pass that folds the result into [0, MODULUS).
module addsub_serial #(
  parameter int SIZE = 448,
  parameter int LIMB = 64
`ifdef ADDSUB_MOD_EN
  ,
  parameter logic [SIZE-1:0] MODULUS = SIZE'(448'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF)
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE:0]   result,
  output logic            done,
  output logic            busy
);

  localparam int NUM_LIMBS = (SIZE + LIMB - 1) / LIMB;
  localparam int TW = NUM_LIMBS * LIMB;
  localparam int IW = $clog2(NUM_LIMBS + 1);

`ifdef ADDSUB_MOD_EN
  localparam logic [SIZE-1:0] MOD_INV = ~MODULUS;
  typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t          state;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;
  logic [TW-1:0]   sum_reg;
  logic            carry;
  logic            op_reg;
  logic [IW-1:0]   idx;
`ifdef ADDSUB_MOD_EN
  logic            fix;
  logic            take_t;
`endif

  logic [SIZE-1:0] b_inv;
  logic [LIMB:0]   limb_sum;
  logic [TW-1:0]   sum_next;
  logic [TW:0]     full;
  logic            last;
  int              base;

  // One limb of the shared adder; full is the whole padded sum including this limb.
  always_comb begin
    b_inv    = ~b;
    base     = int'(idx) * LIMB;
    limb_sum = {1'b0, a_reg[base +: LIMB]} + {1'b0, b_reg[base +: LIMB]} + {{LIMB{1'b0}}, carry};
    sum_next = sum_reg;
    sum_next[base +: LIMB] = limb_sum[LIMB-1:0];
    full     = {limb_sum[LIMB], sum_next};
    last     = (idx == IW'(NUM_LIMBS - 1));
`ifdef ADDSUB_MOD_EN
    take_t   = op_reg ? fix : (fix | full[SIZE]);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      result  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      op_reg  <= 1'b0;
      idx     <= '0;
`ifdef ADDSUB_MOD_EN
      fix     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_reg <= op;
            a_reg  <= TW'(a);
            b_reg  <= op ? TW'(b_inv) : TW'(b);
            carry  <= op;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= limb_sum[LIMB];
          idx     <= idx + 1'b1;
          if (last) begin
`ifdef ADDSUB_MOD_EN
            // Reuse the adder: add subtracts MODULUS (+~M+1), sub adds MODULUS back.
            a_reg <= TW'(sum_next[SIZE-1:0]);
            b_reg <= op_reg ? TW'(MODULUS) : TW'(MOD_INV);
            carry <= ~op_reg;
            idx   <= '0;
            fix   <= op_reg ? ~full[SIZE] : full[SIZE];
            state <= CORR;
`else
            result <= op_reg ? {~full[SIZE], full[SIZE-1:0]} : full[SIZE:0];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
`endif
          end
        end
`ifdef ADDSUB_MOD_EN
        CORR: begin
          sum_reg <= sum_next;
          carry   <= limb_sum[LIMB];
          idx     <= idx + 1'b1;
          if (last) begin
            result <= {1'b0, take_t ? full[SIZE-1:0] : a_reg[SIZE-1:0]};
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
